// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction prefetch buffer.
// Imported by fetch_buffer and fetch_buf_mem.
package fetch_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_WIDTH = 32;

  // addi x0, x0, 0 -- presented to decode whenever the buffer is empty
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_buf_mem.sv
// Storage array for the prefetch buffer: synchronous write, asynchronous read.
// No reset; entries are only observed once the pointer logic marks them valid.
module fetch_buf_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DW    = 2 * DEFAULT_WIDTH,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// Show-ahead instruction prefetch FIFO between fetch and the IF/ID register.
// Optional same-cycle empty bypass enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [WIDTH-1:0]       push_instr_i,
  input  logic [WIDTH-1:0]       push_pc_i,
  input  logic                   pop_ready_i,
  output logic                   pop_valid_o,
  output logic [WIDTH-1:0]       pop_instr_o,
  output logic [WIDTH-1:0]       pop_pc_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [WIDTH-1:0] NOP_W    = WIDTH'(NOP_INSTR);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] head_data;
  logic               empty;
  logic               push_fire;
  logic               pop_fire;
  logic               byp_consume;
  logic               wr_en;

  assign empty        = (count_q == '0);
  assign push_ready_o = (count_q != FULL_CNT);
  assign push_fire    = push_valid_i && push_ready_o;
  // Pop of a stored entry; a bypassed entry never touches the pointers
  assign pop_fire     = pop_ready_i && !empty;
  assign count_o      = count_q;

`ifdef FETCH_BUF_BYPASS_EN
  assign byp_consume = empty && push_fire && pop_ready_i;
`else
  assign byp_consume = 1'b0;
`endif

  assign wr_en = push_fire && !byp_consume && !flush_i;

  fetch_buf_mem #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH),
    .AW    (PW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_en && !reset),
    .waddr_i (wr_ptr_q),
    .wdata_i ({push_instr_i, push_pc_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  always_comb begin
    pop_valid_o = !empty;
    pop_instr_o = empty ? NOP_W : head_data[2*WIDTH-1:WIDTH];
    pop_pc_o    = empty ? '0    : head_data[WIDTH-1:0];
`ifdef FETCH_BUF_BYPASS_EN
    if (empty && push_fire) begin
      pop_valid_o = 1'b1;
      pop_instr_o = push_instr_i;
      pop_pc_o    = push_pc_i;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction prefetch FIFO between instruction-memory fetch logic and the IF/ID pipeline register.
- Decouples fetch from decode stalls. The IF/ID register's enable drives pop_ready_i; its D input takes pop_instr_o / pop_pc_o.
- Branch/jump redirects flush all buffered entries in one cycle.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- WIDTH, 32, instruction and PC width in bits.

Ports:
- clk_i  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- flush_i  input  1  discard all entries; from the branch/jump redirect.
- push_valid_i  input  1  fetch presents an instruction.
- push_ready_o  output  1  buffer can accept an entry; high when count_o < DEPTH.
- push_instr_i  input  WIDTH  fetched instruction.
- push_pc_i  input  WIDTH  PC of the fetched instruction.
- pop_ready_i  input  1  IF/ID register enable (not stalled).
- pop_valid_o  output  1  head entry valid.
- pop_instr_o  output  WIDTH  head instruction; 0x00000013 (NOP) when empty.
- pop_pc_o  output  WIDTH  head PC; 0 when empty.
- count_o  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high on port reset.
- Reset (sampled at clk_i rise): read/write pointers = 0, count_o = 0, pop_valid_o = 0, pop_instr_o = NOP, pop_pc_o = 0, push_ready_o = 1. Storage contents are don't-care.
- Push fires when push_valid_i && push_ready_o. Pop fires when pop_ready_i && pop_valid_o.
- Show-ahead FIFO:
  - pop_* outputs are driven combinationally from the head entry; pop_valid_o = (count_o != 0).
  - Latency push -> pop_valid_o is 1 cycle.
- push_ready_o depends only on count_o (no combinational path from pop_ready_i). When full, a same-cycle pop does not enable a push.
- Simultaneous push and pop on a non-empty buffer: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count_o distinguishes full (DEPTH) from empty (0).
- Pop while empty: ignored. Push while full: ignored, and fetch must hold its data. Neither corrupts pointers.
- flush_i, synchronous: next cycle count_o = 0, pointers = 0, pop_valid_o = 0. A same-cycle push is discarded.
- Priority: reset > flush_i > push/pop.
- Reset asserted mid-stream has the same effect as flush and also restores all reset values.
- Outputs never present X after reset: the empty case forces NOP/0.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- Defined:
  - When empty and a push fires, push_instr_i / push_pc_i drive pop_* combinationally in the same cycle and pop_valid_o = 1. Push-to-pop latency becomes 0.
  - If pop_ready_i is also high that cycle, the entry is consumed and not written; count stays 0.
  - If pop_ready_i is low, the entry is written normally.
- Undefined: no bypass; latency is 1 cycle.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h00000013.
  - Default DEPTH/WIDTH localparams.
  - Pointer-width function ($clog2 wrapper).
- Sub-module: fetch_buf_mem, a DEPTH x (2*WIDTH) register array with synchronous write and asynchronous read. The pointer/count logic stays in the top module.

Test Plan:
- Reset with push_valid_i = 1 for one cycle, then release -> count_o = 0, pop_valid_o = 0, pop_instr_o = 0x00000013, push_ready_o = 1.
- Push instr 0x00500093 / PC 0x0, with pop_ready_i = 0 -> next cycle pop_valid_o = 1, pop_instr_o = 0x00500093, pop_pc_o = 0x0, count_o = 1.
- Push 4 entries (PCs 0x0, 0x4, 0x8, 0xC) with pop_ready_i = 0 -> count_o = 4, push_ready_o = 0. A 5th push is held and ignored. Then pop 4 -> PCs emerge in order 0x0, 0x4, 0x8, 0xC and count_o returns to 0.
- Steady state with simultaneous push and pop every cycle over 10 entries -> count_o constant at 1, pointers wrap past DEPTH, PC order preserved.
- 3 entries buffered, then flush_i = 1 with push_valid_i = 1 (PC 0x40) -> next cycle count_o = 0, pop_valid_o = 0. A subsequent push of PC 0x80 appears as head.
- FETCH_BUF_BYPASS_EN defined, empty buffer: push PC 0x100 with pop_ready_i = 1 -> pop_pc_o = 0x100 in the same cycle, count_o stays 0. Repeat with pop_ready_i = 0 -> count_o = 1.
